// File: rtl/fnd_scan_ctrl_if.sv
// Bus between a value producer and the four-digit FND scan controller.
// The producer side owns the scan tick, value/update request and decimal points.
interface fnd_scan_ctrl_if #(
  parameter int VALUE_W = 14
);
  logic               tick_in;
  logic [VALUE_W-1:0] value;
  logic               update;
  logic [3:0]         dp_mask;
  logic               busy;
  logic [7:0]         seg;
  logic [3:0]         an;

  modport master (output tick_in, value, update, dp_mask, input busy, seg, an);
  modport slave  (input tick_in, value, update, dp_mask, output busy, seg, an);
endinterface

// File: rtl/fnd_scan_ctrl.sv
// Four-digit seven-segment scan controller: tick edge detect, sequential
// double-dabble binary-to-BCD conversion, multiplexed active-low outputs.
module fnd_scan_ctrl #(
  parameter int VALUE_W  = 14,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  fnd_scan_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [VALUE_W-1:0] MAX_VAL = VALUE_W'(32'd9999);
  localparam logic [4:0]         LAST_CNT = 5'(VALUE_W - 1);

  state_t             state_r, state_next_s;
  logic               load_s, shift_s, commit_s, busy_next_s;
  logic [VALUE_W-1:0] v_r, sat_s;
  logic [15:0]        bcd_r, adj_s, disp_r;
  logic [4:0]         cnt_r;
  logic               tick_d_r, scan_en_s;
  logic [1:0]         idx_r, idx_next_s;
  logic [3:0]         nib_s, blank_s;
  logic [7:0]         seg_next_s;

  // Active-low gfedcba pattern for one BCD digit; non-decimal codes are dark.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Conversion state register.
  always_ff @(posedge clk) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= state_next_s;
  end

  // Conversion next-state and control strobes.
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    shift_s      = 1'b0;
    commit_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.update) begin
          state_next_s = SHIFT;
          load_s       = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      SHIFT: begin
        shift_s = 1'b1;
        if (cnt_r == LAST_CNT) state_next_s = DONE;
        else                   state_next_s = SHIFT;
      end
      DONE: begin
        commit_s     = 1'b1;
        state_next_s = IDLE;
      end
      default: state_next_s = IDLE;
    endcase
    if (load_s)        busy_next_s = 1'b1;
    else if (commit_s) busy_next_s = 1'b0;
    else               busy_next_s = bus.busy;
  end

  // Saturated input and add-3 correction applied before each shift.
  always_comb begin
    if (bus.value > MAX_VAL) sat_s = MAX_VAL;
    else                     sat_s = bus.value;
    adj_s = bcd_r;
    for (int k = 0; k < 4; k++) begin
      if (bcd_r[4*k +: 4] >= 4'd5) adj_s[4*k +: 4] = bcd_r[4*k +: 4] + 4'd3;
      else                         adj_s[4*k +: 4] = bcd_r[4*k +: 4];
    end
  end

  // Conversion datapath and display register; a reset discards partial work.
  always_ff @(posedge clk) begin
    if (!reset) begin
      v_r      <= '0;
      bcd_r    <= 16'd0;
      cnt_r    <= 5'd0;
      disp_r   <= 16'd0;
      bus.busy <= 1'b0;
    end else begin
      bus.busy <= busy_next_s;
      if (load_s) begin
        v_r   <= sat_s;
        bcd_r <= 16'd0;
        cnt_r <= 5'd0;
      end else if (shift_s) begin
        bcd_r <= {adj_s[14:0], v_r[VALUE_W-1]};
        v_r   <= {v_r[VALUE_W-2:0], 1'b0};
        cnt_r <= cnt_r + 5'd1;
      end
      if (commit_s) disp_r <= bcd_r;
    end
  end

  // Digit selection, leading-zero blanking and segment word for the next index.
  always_comb begin
    scan_en_s  = bus.tick_in & ~tick_d_r;
    idx_next_s = idx_r + 2'd1;
    case (idx_next_s)
      2'd0:    nib_s = disp_r[3:0];
      2'd1:    nib_s = disp_r[7:4];
      2'd2:    nib_s = disp_r[11:8];
      2'd3:    nib_s = disp_r[15:12];
      default: nib_s = disp_r[3:0];
    endcase
    blank_s[0] = 1'b0;
    blank_s[1] = BLANK_LZ && (disp_r[15:4] == 12'd0);
    blank_s[2] = BLANK_LZ && (disp_r[15:8] == 8'd0);
    blank_s[3] = BLANK_LZ && (disp_r[15:12] == 4'd0);
    if (blank_s[idx_next_s]) seg_next_s = {~bus.dp_mask[idx_next_s], 7'b1111111};
    else                     seg_next_s = {~bus.dp_mask[idx_next_s], seg7(nib_s)};
  end

  // Scan index and registered anode/segment outputs, advanced once per tick edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tick_d_r <= 1'b0;
      idx_r    <= 2'd0;
      bus.an   <= 4'b1111;
      bus.seg  <= 8'hFF;
    end else begin
      tick_d_r <= bus.tick_in;
      if (scan_en_s) begin
        idx_r   <= idx_next_s;
        bus.an  <= ~(4'b0001 << idx_next_s);
        bus.seg <= seg_next_s;
      end
    end
  end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Directed self-checking bench for fnd_scan_ctrl: reset, conversion timing,
// scan order, segment patterns, blanking, saturation, busy ignore and reset abort.
module tb_fnd_scan_ctrl;

  logic       clk;
  logic       reset;
  int         total;
  int         bad;
  logic [1:0] exp_idx;

  fnd_scan_ctrl_if #(.VALUE_W(14)) bus ();

  fnd_scan_ctrl #(.VALUE_W(14), .BLANK_LZ(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  // Request a conversion and measure how many sampled cycles busy stays high.
  task automatic convert(input logic [13:0] v, input string tag);
    int n;
    bus.value  = v;
    bus.update = 1'b1;
    tick_clk();
    bus.update = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      tick_clk();
    end
    chk({tag, "_busy_len"}, n, 15);
  endtask

  // Four tick edges; expected segment words are indexed by digit position.
  task automatic scan4(input logic [7:0] e0, input logic [7:0] e1,
                       input logic [7:0] e2, input logic [7:0] e3, input string tag);
    logic [7:0] exp_seg [4];
    logic [3:0] exp_an;
    exp_seg = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) begin
      bus.tick_in = 1'b1;
      tick_clk();
      exp_idx = exp_idx + 2'd1;
      exp_an  = ~(4'b0001 << exp_idx);
      chk($sformatf("%s_an_d%0d", tag, exp_idx), bus.an, exp_an);
      chk($sformatf("%s_seg_d%0d", tag, exp_idx), bus.seg, exp_seg[exp_idx]);
      bus.tick_in = 1'b0;
      tick_clk();
      chk($sformatf("%s_hold_d%0d", tag, exp_idx), bus.an, exp_an);
    end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    exp_idx     = 2'd0;
    reset       = 1'b0;
    bus.tick_in = 1'b0;
    bus.value   = 14'd0;
    bus.update  = 1'b0;
    bus.dp_mask = 4'b0000;

    // T1: reset held while tick toggles
    for (int i = 0; i < 3; i++) begin
      bus.tick_in = (i % 2 == 0);
      tick_clk();
      chk("t1_an", bus.an, 4'b1111);
      chk("t1_seg", bus.seg, 8'hFF);
      chk("t1_busy", bus.busy, 1'b0);
    end
    bus.tick_in = 1'b0;
    reset       = 1'b1;
    tick_clk();
    chk("t1_an_after", bus.an, 4'b1111);

    // T2: 1234
    convert(14'd1234, "t2");
    scan4(8'h99, 8'hB0, 8'hA4, 8'hF9, "t2");

    // T3: 7 with dp on digit 2
    bus.dp_mask = 4'b0100;
    convert(14'd7, "t3");
    scan4(8'hF8, 8'hFF, 8'h7F, 8'hFF, "t3");
    bus.dp_mask = 4'b0000;

    // T4: saturation and zero
    convert(14'h3FFF, "t4sat");
    scan4(8'h90, 8'h90, 8'h90, 8'h90, "t4sat");
    convert(14'd0, "t4zero");
    scan4(8'hC0, 8'hFF, 8'hFF, 8'hFF, "t4zero");

    // T5: second update while busy is ignored
    begin
      int n;
      bus.value  = 14'd5678;
      bus.update = 1'b1;
      tick_clk();
      bus.update = 1'b0;
      n = 1;
      repeat (4) begin
        if (bus.busy === 1'b1) n++;
        tick_clk();
      end
      bus.value  = 14'd1111;
      bus.update = 1'b1;
      tick_clk();
      bus.update = 1'b0;
      while (bus.busy === 1'b1 && n < 40) begin
        n++;
        tick_clk();
      end
      chk("t5_busy_len", n, 15);
      tick_clk();
      chk("t5_no_requeue", bus.busy, 1'b0);
    end
    scan4(8'h80, 8'hF8, 8'h82, 8'h92, "t5");

    // T6: reset during SHIFT aborts conversion
    bus.value  = 14'd1234;
    bus.update = 1'b1;
    tick_clk();
    bus.update = 1'b0;
    repeat (6) tick_clk();
    chk("t6_busy_mid", bus.busy, 1'b1);
    reset = 1'b0;
    tick_clk();
    chk("t6_busy_rst", bus.busy, 1'b0);
    chk("t6_an_rst", bus.an, 4'b1111);
    chk("t6_seg_rst", bus.seg, 8'hFF);
    exp_idx     = 2'd0;
    bus.tick_in = 1'b1;
    reset       = 1'b1;
    tick_clk();
    exp_idx = 2'd1;
    chk("t6_first_edge_an", bus.an, 4'b1101);
    chk("t6_first_edge_seg", bus.seg, 8'hFF);
    bus.tick_in = 1'b0;
    tick_clk();
    chk("t6_busy_idle", bus.busy, 1'b0);
    scan4(8'hC0, 8'hFF, 8'hFF, 8'hFF, "t6clr");
    convert(14'd42, "t6");
    scan4(8'hA4, 8'h99, 8'hFF, 8'hFF, "t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
